// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: bus widths, bridge FSM encodings and the
// data value returned with an error termination.
package wishbone_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = 4;

  localparam logic [WB_DATA_WIDTH-1:0] WB_ERR_DATA = '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

endpackage : wishbone_pkg

// File: rtl/wishbone_timeout_counter.sv
// Clearable, enabled up-counter that saturates at LIMIT-1 and flags that
// terminal count; used to bound how long a slave may take to respond.
module wishbone_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic in_clock,
  input  logic in_reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign terminal = (count_q == LAST);

endmodule : wishbone_timeout_counter

// File: rtl/wishbone_register_bank_bridge.sv
// Single-master Wishbone classic bridge: decodes a request onto one of
// NUM_SLAVES register slaves and returns a registered one-cycle ack or err.
module wishbone_register_bank_bridge
  import wishbone_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter int          SEL_BITS       = 2,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] BASE_MASK      = 32'hFFFF_FFF0,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                              in_clock,
  input  logic                              in_reset_n,
  input  logic                              in_wb_cyc,
  input  logic                              in_wb_stb,
  input  logic                              in_wb_we,
  input  logic [31:0]                       in_wb_adr,
  input  logic [WB_SEL_WIDTH-1:0]           in_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0]          in_wb_dat,
  output logic                              out_wb_ack,
  output logic                              out_wb_err,
  output logic [WB_DATA_WIDTH-1:0]          out_wb_dat,
  output logic [NUM_SLAVES-1:0]             out_s_cyc,
  output logic [NUM_SLAVES-1:0]             out_s_stb,
  output logic                              out_s_we,
  output logic [WB_SEL_WIDTH-1:0]           out_s_sel,
  output logic [WB_DATA_WIDTH-1:0]          out_s_dat,
  input  logic [NUM_SLAVES-1:0]             in_s_ack,
  input  logic [WB_DATA_WIDTH*NUM_SLAVES-1:0] in_s_dat
);

  logic [1:0]               state_q, state_d;
  logic [SEL_BITS-1:0]      idx_q, req_idx, strobe_idx;
  logic                     req, req_hit, slave_ack, tmo_terminal;
  logic [WB_DATA_WIDTH-1:0] slave_dat;
  logic [NUM_SLAVES-1:0]    strobe_d;

  assign req     = in_wb_cyc & in_wb_stb;
  assign req_idx = in_wb_adr[SEL_BITS+1:2];
  assign req_hit = ((in_wb_adr & BASE_MASK) == BASE_ADDR) &&
                   (int'(req_idx) < NUM_SLAVES);

  // Only the addressed slave's ack and data are observed.
  always_comb begin
    // NOTE: defaults first so no path through the block leaves a latch.
    slave_ack = 1'b0;
    slave_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (int'(idx_q) == k) begin
        slave_ack = in_s_ack[k];
        slave_dat = in_s_dat[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = req_hit ? ST_BUSY : ST_ERR;
      ST_BUSY: begin
        if (!in_wb_cyc)        state_d = ST_IDLE;
        else if (slave_ack)    state_d = ST_RESP;
        else if (tmo_terminal) state_d = ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The slave strobe is driven from next state so it drops on the ack edge.
  always_comb begin
    strobe_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
    strobe_d   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      strobe_d[k] = (state_d == ST_BUSY) && (int'(strobe_idx) == k);
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      out_s_cyc  <= '0;
      out_s_stb  <= '0;
      out_s_we   <= 1'b0;
      out_s_sel  <= '0;
      out_s_dat  <= '0;
      out_wb_ack <= 1'b0;
      out_wb_err <= 1'b0;
      out_wb_dat <= '0;
    end else begin
      state_q    <= state_d;
      out_s_cyc  <= strobe_d;
      out_s_stb  <= strobe_d;
      out_wb_ack <= (state_d == ST_RESP);
      out_wb_err <= (state_d == ST_ERR);
      out_wb_dat <= ((state_d == ST_RESP) && !out_s_we) ? slave_dat : WB_ERR_DATA;
      if ((state_q == ST_IDLE) && req) begin
        idx_q     <= req_idx;
        out_s_we  <= in_wb_we;
        out_s_sel <= in_wb_sel;
        out_s_dat <= in_wb_dat;
      end
    end
  end

  wishbone_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .clear      (state_q != ST_BUSY),
    .enable     (state_q == ST_BUSY),
    .terminal   (tmo_terminal)
  );

endmodule : wishbone_register_bank_bridge

// File: tb/tb_wishbone_register_bank_bridge.sv
// Directed bench for wishbone_register_bank_bridge: a transaction-level
// timing model predicts every output each cycle; literals pin the model.
module tb_wishbone_register_bank_bridge;

  localparam int          NS    = 4;
  localparam int          TMO   = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] SPURD = 32'hDEAD_BEEF;

  logic          in_clock = 1'b0;
  logic          in_reset_n;
  logic          in_wb_cyc, in_wb_stb, in_wb_we;
  logic [31:0]   in_wb_adr, in_wb_dat;
  logic [3:0]    in_wb_sel;
  logic          out_wb_ack, out_wb_err;
  logic [31:0]   out_wb_dat;
  logic [NS-1:0] out_s_cyc, out_s_stb;
  logic          out_s_we;
  logic [3:0]    out_s_sel;
  logic [31:0]   out_s_dat;
  logic [NS-1:0] in_s_ack;
  logic [32*NS-1:0] in_s_dat;

  wishbone_register_bank_bridge dut (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .in_wb_cyc  (in_wb_cyc),
    .in_wb_stb  (in_wb_stb),
    .in_wb_we   (in_wb_we),
    .in_wb_adr  (in_wb_adr),
    .in_wb_sel  (in_wb_sel),
    .in_wb_dat  (in_wb_dat),
    .out_wb_ack (out_wb_ack),
    .out_wb_err (out_wb_err),
    .out_wb_dat (out_wb_dat),
    .out_s_cyc  (out_s_cyc),
    .out_s_stb  (out_s_stb),
    .out_s_we   (out_s_we),
    .out_s_sel  (out_s_sel),
    .out_s_dat  (out_s_dat),
    .in_s_ack   (in_s_ack),
    .in_s_dat   (in_s_dat)
  );

  always #5 in_clock = ~in_clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected outputs for the current cycle, set by the model after each edge.
  logic          exp_valid = 1'b0;
  logic          exp_ack, exp_err, exp_we;
  logic [31:0]   exp_dat, exp_sdat;
  logic [NS-1:0] exp_cyc;
  logic [3:0]    exp_sel;

  always @(negedge in_clock) begin
    if (exp_valid) begin
      check("s_cyc",  32'(out_s_cyc), 32'(exp_cyc));
      check("s_stb",  32'(out_s_stb), 32'(exp_cyc));
      check("wb_ack", 32'(out_wb_ack), 32'(exp_ack));
      check("wb_err", 32'(out_wb_err), 32'(exp_err));
      check("wb_dat", out_wb_dat, exp_dat);
      check("s_we",   32'(out_s_we), 32'(exp_we));
      check("s_sel",  32'(out_s_sel), 32'(exp_sel));
      check("s_dat",  out_s_dat, exp_sdat);
    end
  end

  // Independent observers feeding the hand-computed literal checks.
  int            stb3_cnt = 0, ack_cnt = 0, err_cnt = 0;
  logic [31:0]   last_ack_dat = '0;
  logic [NS-1:0] last_stb = '0;

  always @(negedge in_clock) begin
    if (in_reset_n) begin
      if (out_s_stb[3]) stb3_cnt++;
      if (|out_s_stb) last_stb = out_s_stb;
      if (out_wb_ack) begin ack_cnt++; last_ack_dat = out_wb_dat; end
      if (out_wb_err) err_cnt++;
    end
  end

  // Called #1 after a clock edge with the bridge idle. ack_edge/abort_edge/
  // spur_edge are edge numbers counted from the edge sampling the request
  // (0 = never). The termination edge follows from the bus rules alone.
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdat, input int ack_edge,
                         input logic [31:0] rdata, input int abort_edge, input int spur_edge);
    logic [1:0]    idx;
    logic          hit;
    logic [NS-1:0] oh;
    int            e;
    int            kind; // 0 miss, 1 ack, 2 timeout, 3 abort
    idx = adr[3:2];
    hit = ((adr & MASK) == BASE) && (int'(idx) < NS);
    oh  = NS'(1) << idx;
    if (!hit)                                                    begin kind = 0; e = 0;          end
    else if (abort_edge != 0 && abort_edge <= TMO &&
             (ack_edge == 0 || abort_edge <= ack_edge))          begin kind = 3; e = abort_edge; end
    else if (ack_edge != 0 && ack_edge < TMO)                    begin kind = 1; e = ack_edge;   end
    else                                                         begin kind = 2; e = TMO;        end

    in_wb_cyc = 1'b1; in_wb_stb = 1'b1;
    in_wb_we = we; in_wb_adr = adr; in_wb_sel = sel; in_wb_dat = wdat;
    in_s_dat = '0;
    in_s_dat[int'(idx)*32 +: 32] = rdata;
    if (idx != 2'd0) in_s_dat[31:0] = SPURD;

    for (int c = 0; c <= e + 1; c++) begin
      @(posedge in_clock); #1;
      exp_valid = 1'b1;
      exp_we    = we;
      exp_sel   = sel;
      exp_sdat  = wdat;
      exp_cyc   = (hit && c < e) ? oh : '0;
      exp_ack   = (kind == 1) && (c == e);
      exp_err   = (kind == 0 || kind == 2) && (c == e);
      exp_dat   = (exp_ack && !we) ? rdata : 32'h0;
      in_s_ack  = '0;
      if (ack_edge != 0 && c + 1 == ack_edge) in_s_ack[idx] = 1'b1;
      if (spur_edge != 0 && c + 1 == spur_edge) in_s_ack[0] = 1'b1;
      if ((abort_edge != 0 && c + 1 == abort_edge) || c == e) begin
        in_wb_cyc = 1'b0; in_wb_stb = 1'b0;
      end
    end
    in_s_ack = '0;
  endtask

  initial begin
    int a0, e0;
    in_reset_n = 1'b0;
    in_wb_cyc = 0; in_wb_stb = 0; in_wb_we = 0;
    in_wb_adr = '0; in_wb_sel = '0; in_wb_dat = '0;
    in_s_ack = '0; in_s_dat = '0;
    exp_cyc = '0; exp_ack = 0; exp_err = 0; exp_dat = '0;
    exp_we = 0; exp_sel = '0; exp_sdat = '0;
    repeat (2) @(posedge in_clock);
    #1;
    check("reset_ack", 32'(out_wb_ack), 32'h0);
    check("reset_err", 32'(out_wb_err), 32'h0);
    check("reset_cyc", 32'(out_s_cyc), 32'h0);
    @(negedge in_clock) in_reset_n = 1'b1;
    @(posedge in_clock); #1;
    exp_valid = 1'b1;

    // Write to slave 2: strobe one-hot 0100, held data, ack after edge 2.
    a0 = ack_cnt; e0 = err_cnt;
    run_txn(32'h3000_0008, 1'b1, 4'hF, 32'hA5A5_1234, 2, 32'h1111_2222, 0, 0);
    check("wr_stb_onehot", 32'(last_stb), 32'h4);
    check("wr_held_dat", out_s_dat, 32'hA5A5_1234);
    check("wr_one_ack", 32'(ack_cnt - a0), 32'd1);
    check("wr_no_err", 32'(err_cnt - e0), 32'd0);

    // Read slave 1 while slave 0 acks spuriously first.
    run_txn(32'h3000_0004, 1'b0, 4'hF, 32'h0, 3, 32'h0000_00FF, 0, 2);
    check("rd_ack_dat", last_ack_dat, 32'h0000_00FF);

    // Unmapped address.
    e0 = err_cnt;
    run_txn(32'h3000_0100, 1'b0, 4'h3, 32'h0, 0, 32'h0, 0, 0);
    check("miss_err", 32'(err_cnt - e0), 32'd1);

    // Slave 3 never responds: strobe held 16 cycles then err.
    stb3_cnt = 0; e0 = err_cnt;
    run_txn(32'h3000_000C, 1'b0, 4'hF, 32'h0, 0, 32'h0, 0, 0);
    check("tmo_stb_cycles", 32'(stb3_cnt), 32'd16);
    check("tmo_err", 32'(err_cnt - e0), 32'd1);

    // Master abort mid-BUSY, then a normal read of the same slave.
    a0 = ack_cnt; e0 = err_cnt;
    run_txn(32'h3000_0008, 1'b0, 4'hF, 32'h0, 5, 32'h0BAD_0BAD, 3, 0);
    check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("abort_no_err", 32'(err_cnt - e0), 32'd0);
    run_txn(32'h3000_0008, 1'b0, 4'h6, 32'h0, 2, 32'h1234_5678, 0, 0);
    check("post_abort_dat", last_ack_dat, 32'h1234_5678);

    // Asynchronous reset in the middle of a BUSY cycle.
    exp_valid = 1'b0;
    in_wb_cyc = 1; in_wb_stb = 1; in_wb_we = 1;
    in_wb_adr = 32'h3000_0008; in_wb_sel = 4'hF; in_wb_dat = 32'h5555_AAAA;
    repeat (2) @(posedge in_clock);
    #3 in_reset_n = 1'b0;
    #1;
    check("arst_cyc", 32'(out_s_cyc), 32'h0);
    check("arst_stb", 32'(out_s_stb), 32'h0);
    check("arst_we",  32'(out_s_we), 32'h0);
    check("arst_sel", 32'(out_s_sel), 32'h0);
    check("arst_sdat", out_s_dat, 32'h0);
    check("arst_ack", 32'(out_wb_ack), 32'h0);
    check("arst_err", 32'(out_wb_err), 32'h0);
    in_wb_cyc = 0; in_wb_stb = 0;
    @(negedge in_clock) in_reset_n = 1'b1;
    @(posedge in_clock); #1;
    run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, 4, 32'hCAFE_0001, 0, 0);
    check("post_rst_dat", last_ack_dat, 32'hCAFE_0001);

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_wishbone_register_bank_bridge
